// File: rtl/dram_arbiter_if.sv
// rtl/dram_arbiter_if.sv - two-requester shared-RAM bus bundle for dram_arbiter
interface dram_arbiter_if;
   logic [31:0] m0_address;
   logic        m0_read;
   logic        m0_write;
   logic [31:0] m0_writedata;
   logic        m0_waitrequest;
   logic [31:0] m0_readdata;

   logic [31:0] m1_address;
   logic        m1_read;
   logic        m1_write;
   logic [31:0] m1_writedata;
   logic        m1_waitrequest;
   logic [31:0] m1_readdata;

   logic [31:0] mem_address;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;

   logic        proto_err;

   // requester/RAM side of the bundle
   modport master (
      output m0_address, m0_read, m0_write, m0_writedata,
      input  m0_waitrequest, m0_readdata,
      output m1_address, m1_read, m1_write, m1_writedata,
      input  m1_waitrequest, m1_readdata,
      input  mem_address, mem_read, mem_write, mem_writedata,
      output mem_readdata,
      input  proto_err
   );

   // arbiter side of the bundle
   modport slave (
      input  m0_address, m0_read, m0_write, m0_writedata,
      output m0_waitrequest, m0_readdata,
      input  m1_address, m1_read, m1_write, m1_writedata,
      output m1_waitrequest, m1_readdata,
      output mem_address, mem_read, mem_write, mem_writedata,
      input  mem_readdata,
      output proto_err
   );
endinterface

// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - round-robin two-requester arbiter for a shared RAM
module dram_arbiter #(
   parameter int unsigned STALL_CYCLES = 1
) (
   input logic           clk,
   input logic           reset_n,
   dram_arbiter_if.slave bus
);

   localparam logic [3:0] STALL = 4'(STALL_CYCLES);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        prio_q, prio_d;
   logic        err_q, err_d;

   logic        req0, req1;
   logic        own_rd, own_wr;
   logic [31:0] own_addr, own_wd;

   logic        wait0, wait1;
   logic [31:0] rdata0, rdata1;
   logic [31:0] mem_addr_c, mem_wd_c;
   logic        mem_rd_c, mem_wr_c;

   assign req0 = bus.m0_read | bus.m0_write;
   assign req1 = bus.m1_read | bus.m1_write;

   assign own_rd   = owner_q ? bus.m1_read      : bus.m0_read;
   assign own_wr   = owner_q ? bus.m1_write     : bus.m0_write;
   assign own_addr = owner_q ? bus.m1_address   : bus.m0_address;
   assign own_wd   = owner_q ? bus.m1_writedata : bus.m0_writedata;

   // state register; reset abandons any access in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         cnt_q   <= 4'd0;
         prio_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         prio_q  <= prio_d;
         err_q   <= err_d;
      end
   end

   // arbitration, stall counting and bus steering
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      prio_d     = prio_q;
      err_d      = err_q;
      wait0      = req0;
      wait1      = req1;
      rdata0     = 32'd0;
      rdata1     = 32'd0;
      mem_addr_c = 32'd0;
      mem_wd_c   = 32'd0;
      mem_rd_c   = 1'b0;
      mem_wr_c   = 1'b0;

      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               state_d = ACCESS;
               cnt_d   = STALL;
               owner_d = (req0 && req1) ? prio_q : req1;
            end
         end
         ACCESS: begin
            mem_addr_c = own_addr;
            mem_wd_c   = own_wd;
            // read+write together is treated as a write
            mem_rd_c   = own_rd & ~own_wr;
            if (!(own_rd || own_wr)) begin
               // owner dropped its request mid-access: abort without writing
               err_d   = 1'b1;
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else begin
               if (own_rd && own_wr) begin
                  err_d = 1'b1;
               end
               if (cnt_q != 4'd0) begin
                  cnt_d = cnt_q - 4'd1;
               end else begin
                  mem_wr_c = own_wr;
                  state_d  = IDLE;
                  prio_d   = ~owner_q;
                  if (owner_q) begin
                     wait1 = 1'b0;
                     if (own_rd && !own_wr) rdata1 = bus.mem_readdata;
                  end else begin
                     wait0 = 1'b0;
                     if (own_rd && !own_wr) rdata0 = bus.mem_readdata;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.m0_waitrequest = wait0;
   assign bus.m1_waitrequest = wait1;
   assign bus.m0_readdata    = rdata0;
   assign bus.m1_readdata    = rdata1;
   assign bus.mem_address    = mem_addr_c;
   assign bus.mem_writedata  = mem_wd_c;
   assign bus.mem_read       = mem_rd_c;
   assign bus.mem_write      = mem_wr_c;
   assign bus.proto_err      = err_q;

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter STALL_CYCLES, default 1, SHALL set the wait cycles inserted per granted access; legal range 0..15.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 m0_address / m1_address  input  32  requester word address.
REQ-005 m0_read / m1_read  input  1  read request.
REQ-006 m0_write / m1_write  input  1  write request.
REQ-007 m0_writedata / m1_writedata  input  32  write data.
REQ-008 m0_waitrequest / m1_waitrequest  output  1  stall, Avalon-style.
REQ-009 m0_readdata / m1_readdata  output  32  read data, valid only in the completion cycle.
REQ-010 mem_address  output  32  shared RAM address.
REQ-011 mem_read  output  1  shared RAM read strobe.
REQ-012 mem_write  output  1  shared RAM write strobe.
REQ-013 mem_writedata  output  32  shared RAM write data.
REQ-014 mem_readdata  input  32  RAM combinational read data.
REQ-015 proto_err  output  1  sticky protocol-error flag.

Function
REQ-016 Requester N SHALL be requesting when mN_read or mN_write is 1; it holds address, data and strobes stable while mN_waitrequest is 1.
REQ-017 The block SHALL have states IDLE and ACCESS, plus registers owner (1 bit), cnt (4 bits) and prio (1 bit, the favoured requester).
REQ-018 IDLE, no request: the block SHALL stay in IDLE.
REQ-019 IDLE, one requester: the block SHALL go to ACCESS with owner set to that requester and cnt set to STALL_CYCLES.
REQ-020 IDLE, both requesting: owner SHALL be prio.
REQ-021 ACCESS with cnt>0: cnt SHALL decrement and owner's waitrequest SHALL be 1.
REQ-022 ACCESS with cnt==0 is the completion cycle: owner's waitrequest SHALL be 0, the next state SHALL be IDLE, and prio SHALL become the non-owner.
REQ-023 In ACCESS, mem_address, mem_writedata and mem_read SHALL follow the owner's inputs.
REQ-024 mem_write SHALL be 1 only in the completion cycle, so each write reaches the RAM exactly once.
REQ-025 In IDLE, mem_read, mem_write, mem_address and mem_writedata SHALL all be 0.
REQ-026 mN_readdata SHALL equal mem_readdata in owner N's read completion cycle, else 0.
REQ-027 A non-owner that is requesting SHALL see waitrequest 1; a requester that is not requesting SHALL see waitrequest 0.
REQ-028 In IDLE, every requesting requester SHALL see waitrequest 1.
REQ-029 Latency: a request sampled in IDLE at edge T SHALL complete in the cycle following edge T+STALL_CYCLES, giving STALL_CYCLES+2 cycles per access including IDLE.
REQ-030 A requester seeing continuous contention SHALL wait at most one foreign access, so round-robin is starvation-free.
REQ-031 Read and write asserted together by one requester SHALL be executed as a write and SHALL set proto_err.
REQ-032 If the owner deasserts its request while in ACCESS, proto_err SHALL be set, the next state SHALL be IDLE, and no mem_write SHALL be issued.
REQ-033 A requester may present a new request in the cycle after its own completion; it SHALL then be arbitrated as a normal IDLE request against the other requester.
REQ-034 cnt SHALL NOT wrap; STALL_CYCLES=0 SHALL complete in the first ACCESS cycle.

Reset
REQ-035 reset_n low SHALL immediately force state IDLE, owner 0, cnt 0, prio 0 and proto_err 0, regardless of clk.
REQ-036 A transaction in flight when reset asserts SHALL be abandoned with no mem_write issued, and the requester SHALL re-issue it after reset.
REQ-037 After reset_n rises, the first edge SHALL behave as IDLE.

Verification
REQ-038 STALL_CYCLES=1, m0 reads 0x0, RAM[0]=0x12345678 -> m0_waitrequest=1 for 2 cycles, then m0_readdata=0x12345678 with waitrequest 0.
REQ-039 m0 and m1 write simultaneously after reset (m0 data 0xAAAA0000 to 0x4, m1 data 0xBBBB0000 to 0x8) -> m0 granted first, then m1; exactly one mem_write pulse each; RAM[4]=0xAAAA0000, RAM[8]=0xBBBB0000.
REQ-040 Both requesting continuously for 6 accesses -> grants alternate 0,1,0,1,0,1; each requester waits no more than one foreign access.
REQ-041 STALL_CYCLES=0, m1 alone reads 0x10 -> completes one cycle after sampling, total 2 cycles; mem_read is 0 while IDLE.
REQ-042 reset_n pulled low mid-ACCESS of an m0 write -> no mem_write pulse, outputs return to IDLE values asynchronously, prio=0.
REQ-043 m1 asserts read and write together -> write performed and proto_err=1, held until reset.
